// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
// Central sequencer for pipeline control hazards: load-use stalls, taken-branch
// and jump redirects, and data-memory busy stalls. One registered FSM drives PC
// write-enable, PC source/target, IF/ID write-enable and the per-stage flushes.
// Every output is registered: a decision made on an edge is visible for the
// following cycle.
//
// Optional build macro HAZ_PERF_CNT_EN adds 16-bit saturating performance
// counters (branch redirects, jump redirects, cycles with pc_write low).

module pipeline_hazard_controller #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned REG_W        = 5,
  parameter int unsigned REDIRECT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_jump,
  input  logic [ADDR_W-1:0] id_jump_target,
  input  logic              ex_branch,
  input  logic              ex_alu_zero,
  input  logic [ADDR_W-1:0] ex_branch_target,
  input  logic              ex_mem_read,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic              mem_busy,
  output logic              pc_write,
  output logic [1:0]        pc_sel,
  output logic [ADDR_W-1:0] pc_target,
  output logic              if_id_write,
  output logic              if_flush,
  output logic              id_flush,
  output logic              ex_flush,
  output logic [1:0]        ctrl_state
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0]       perf_branch_cnt,
  output logic [15:0]       perf_jump_cnt,
  output logic [15:0]       perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    StRun      = 2'b00,
    StStall    = 2'b01,
    StRedirect = 2'b10,
    StMemWait  = 2'b11
  } state_e;

  localparam logic [1:0] PcSeq    = 2'b00;
  localparam logic [1:0] PcJump   = 2'b01;
  localparam logic [1:0] PcBranch = 2'b10;

  // Counter value after a redirect; the flushed window lasts REDIRECT_CYC cycles.
  localparam logic [2:0] CntInit = 3'(REDIRECT_CYC - 1);
  // Single-cycle redirects never enter the REDIRECT state.
  localparam state_e RedirNext = (REDIRECT_CYC > 1) ? StRedirect : StRun;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;

  logic              pc_write_q, pc_write_d;
  logic              if_id_write_q, if_id_write_d;
  logic [1:0]        pc_sel_q, pc_sel_d;
  logic [ADDR_W-1:0] pc_target_q, pc_target_d;
  logic              if_flush_q, if_flush_d;
  logic              id_flush_q, id_flush_d;
  logic              ex_flush_q, ex_flush_d;

  logic              taken;
  logic              loaduse;

  assign taken   = ex_branch & ex_alu_zero;
  assign loaduse = ex_mem_read & (ex_rd != '0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  // State and redirect counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; fixed priority mem_busy > branch > jump > load-use
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StRun: begin
        if (mem_busy) begin
          state_d = StMemWait;
        end else if (taken || id_jump) begin
          state_d = RedirNext;
          cnt_d   = CntInit;
        end else if (loaduse) begin
          state_d = StStall;
        end
      end
      StStall: begin
        state_d = mem_busy ? StMemWait : StRun;
      end
      StRedirect: begin
        // mem_busy freezes the counter; the last flushed cycle is at count 0
        if (!mem_busy) begin
          if (cnt_q == 3'd0) begin
            state_d = StRun;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      StMemWait: begin
        if (!mem_busy) begin
          state_d = StRun;
        end
      end
      default: begin
        state_d = StRun;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Next-output logic; outputs are registered below
  always_comb begin
    pc_write_d    = 1'b1;
    if_id_write_d = 1'b1;
    pc_sel_d      = PcSeq;
    pc_target_d   = pc_target_q;
    if_flush_d    = 1'b0;
    id_flush_d    = 1'b0;
    ex_flush_d    = 1'b0;
    unique case (state_q)
      StRun: begin
        if (mem_busy) begin
          pc_write_d    = 1'b0;
          if_id_write_d = 1'b0;
        end else if (taken) begin
          // Branch is older than the jump in ID, so it wins and flushes it
          pc_sel_d    = PcBranch;
          pc_target_d = ex_branch_target;
          if_flush_d  = 1'b1;
          id_flush_d  = 1'b1;
          ex_flush_d  = 1'b1;
        end else if (id_jump) begin
          pc_sel_d    = PcJump;
          pc_target_d = id_jump_target;
          if_flush_d  = 1'b1;
          id_flush_d  = 1'b1;
        end else if (loaduse) begin
          // Hold PC and IF/ID, insert a bubble into EX via id_flush
          pc_write_d    = 1'b0;
          if_id_write_d = 1'b0;
          id_flush_d    = 1'b1;
        end
      end
      StStall: begin
        if (mem_busy) begin
          pc_write_d    = 1'b0;
          if_id_write_d = 1'b0;
        end
      end
      StRedirect: begin
        if (mem_busy) begin
          pc_write_d    = 1'b0;
          if_id_write_d = 1'b0;
          if_flush_d    = if_flush_q;
          id_flush_d    = id_flush_q;
          ex_flush_d    = ex_flush_q;
        end else if (cnt_q != 3'd0) begin
          // Keep the originating flush pattern for the rest of the window
          if_flush_d = if_flush_q;
          id_flush_d = id_flush_q;
          ex_flush_d = ex_flush_q;
        end
      end
      StMemWait: begin
        if (mem_busy) begin
          pc_write_d    = 1'b0;
          if_id_write_d = 1'b0;
        end
      end
      default: begin
        pc_write_d    = 1'b1;
        if_id_write_d = 1'b1;
      end
    endcase
  end

  // Output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_write_q    <= 1'b1;
      if_id_write_q <= 1'b1;
      pc_sel_q      <= PcSeq;
      pc_target_q   <= '0;
      if_flush_q    <= 1'b0;
      id_flush_q    <= 1'b0;
      ex_flush_q    <= 1'b0;
    end else begin
      pc_write_q    <= pc_write_d;
      if_id_write_q <= if_id_write_d;
      pc_sel_q      <= pc_sel_d;
      pc_target_q   <= pc_target_d;
      if_flush_q    <= if_flush_d;
      id_flush_q    <= id_flush_d;
      ex_flush_q    <= ex_flush_d;
    end
  end

  assign pc_write    = pc_write_q;
  assign if_id_write = if_id_write_q;
  assign pc_sel      = pc_sel_q;
  assign pc_target   = pc_target_q;
  assign if_flush    = if_flush_q;
  assign id_flush    = id_flush_q;
  assign ex_flush    = ex_flush_q;
  assign ctrl_state  = state_q;

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] perf_branch_q, perf_jump_q, perf_stall_q;
  logic        branch_acc, jump_acc;

  assign branch_acc = (state_q == StRun) & ~mem_busy & taken;
  assign jump_acc   = (state_q == StRun) & ~mem_busy & ~taken & id_jump;

  // Saturating event counters; stall counts each completed cycle with pc_write low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branch_q <= 16'd0;
      perf_jump_q   <= 16'd0;
      perf_stall_q  <= 16'd0;
    end else begin
      if (branch_acc && (perf_branch_q != 16'hFFFF)) begin
        perf_branch_q <= perf_branch_q + 16'd1;
      end
      if (jump_acc && (perf_jump_q != 16'hFFFF)) begin
        perf_jump_q <= perf_jump_q + 16'd1;
      end
      if (!pc_write_q && (perf_stall_q != 16'hFFFF)) begin
        perf_stall_q <= perf_stall_q + 16'd1;
      end
    end
  end

  assign perf_branch_cnt = perf_branch_q;
  assign perf_jump_cnt   = perf_jump_q;
  assign perf_stall_cnt  = perf_stall_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller. Two instances share stimulus:
// dut_a with REDIRECT_CYC=3 and dut_b with REDIRECT_CYC=2. Control outputs are
// packed as {pc_write, if_id_write, pc_sel, if_flush, id_flush, ex_flush, ctrl_state}.

module tb_pipeline_hazard_controller;

  localparam int unsigned AW = 32;
  localparam int unsigned RW = 5;

  localparam logic [8:0] CtlRun     = 9'b1_1_00_0_0_0_00;
  localparam logic [8:0] CtlStall   = 9'b0_0_00_0_1_0_01;
  localparam logic [8:0] CtlMemWait = 9'b0_0_00_0_0_0_11;
  localparam logic [8:0] CtlBrRedir = 9'b1_1_10_1_1_1_10;
  localparam logic [8:0] CtlBrRun   = 9'b1_1_10_1_1_1_00;
  localparam logic [8:0] CtlJmpRed  = 9'b1_1_01_1_1_0_10;
  localparam logic [8:0] CtlBrHold  = 9'b1_1_00_1_1_1_10;
  localparam logic [8:0] CtlJmpHold = 9'b1_1_00_1_1_0_10;
  localparam logic [8:0] CtlBrBusy  = 9'b0_0_00_1_1_1_10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_jump;
  logic [AW-1:0] id_jump_target;
  logic          ex_branch;
  logic          ex_alu_zero;
  logic [AW-1:0] ex_branch_target;
  logic          ex_mem_read;
  logic [RW-1:0] ex_rd;
  logic [RW-1:0] id_rs1;
  logic [RW-1:0] id_rs2;
  logic          mem_busy;

  logic          pcw_a, ifw_a, iff_a, idf_a, exf_a;
  logic [1:0]    sel_a, st_a;
  logic [AW-1:0] tgt_a;
  logic          pcw_b, ifw_b, iff_b, idf_b, exf_b;
  logic [1:0]    sel_b, st_b;
  logic [AW-1:0] tgt_b;
  logic [8:0]    ctl_a, ctl_b;

  int checks = 0;
  int errors = 0;

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] pbr_a, pjp_a, pst_a, pbr_b, pjp_b, pst_b;
  logic [15:0] stall_base;
`endif

  always #5 clk = ~clk;

  assign ctl_a = {pcw_a, ifw_a, sel_a, iff_a, idf_a, exf_a, st_a};
  assign ctl_b = {pcw_b, ifw_b, sel_b, iff_b, idf_b, exf_b, st_b};

  pipeline_hazard_controller #(
    .ADDR_W      (AW),
    .REG_W       (RW),
    .REDIRECT_CYC(3)
  ) dut_a (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_jump         (id_jump),
    .id_jump_target  (id_jump_target),
    .ex_branch       (ex_branch),
    .ex_alu_zero     (ex_alu_zero),
    .ex_branch_target(ex_branch_target),
    .ex_mem_read     (ex_mem_read),
    .ex_rd           (ex_rd),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .mem_busy        (mem_busy),
    .pc_write        (pcw_a),
    .pc_sel          (sel_a),
    .pc_target       (tgt_a),
    .if_id_write     (ifw_a),
    .if_flush        (iff_a),
    .id_flush        (idf_a),
    .ex_flush        (exf_a),
    .ctrl_state      (st_a)
`ifdef HAZ_PERF_CNT_EN
    ,
    .perf_branch_cnt (pbr_a),
    .perf_jump_cnt   (pjp_a),
    .perf_stall_cnt  (pst_a)
`endif
  );

  pipeline_hazard_controller #(
    .ADDR_W      (AW),
    .REG_W       (RW),
    .REDIRECT_CYC(2)
  ) dut_b (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_jump         (id_jump),
    .id_jump_target  (id_jump_target),
    .ex_branch       (ex_branch),
    .ex_alu_zero     (ex_alu_zero),
    .ex_branch_target(ex_branch_target),
    .ex_mem_read     (ex_mem_read),
    .ex_rd           (ex_rd),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .mem_busy        (mem_busy),
    .pc_write        (pcw_b),
    .pc_sel          (sel_b),
    .pc_target       (tgt_b),
    .if_id_write     (ifw_b),
    .if_flush        (iff_b),
    .id_flush        (idf_b),
    .ex_flush        (exf_b),
    .ctrl_state      (st_b)
`ifdef HAZ_PERF_CNT_EN
    ,
    .perf_branch_cnt (pbr_b),
    .perf_jump_cnt   (pjp_b),
    .perf_stall_cnt  (pst_b)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    id_jump          = 1'b0;
    id_jump_target   = '0;
    ex_branch        = 1'b0;
    ex_alu_zero      = 1'b0;
    ex_branch_target = '0;
    ex_mem_read      = 1'b0;
    ex_rd            = '0;
    id_rs1           = '0;
    id_rs2           = '0;
    mem_busy         = 1'b0;
  endtask

  // Advance one clock and sample 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #12;
    check_eq("reset_ctl_a", 32'(ctl_a), 32'(CtlRun));
    check_eq("reset_tgt_a", tgt_a, 32'h0);
    rst_n = 1'b1;
    step();
    check_eq("idle_ctl_a", 32'(ctl_a), 32'(CtlRun));

    // Load-use on rs2; hazard held through STALL to show it is ignored there
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd3; id_rs2 = 5'd5;
    step();
    check_eq("loaduse_stall_a", 32'(ctl_a), 32'(CtlStall));
    step();
    check_eq("loaduse_release_a", 32'(ctl_a), 32'(CtlRun));
    clear_inputs();
    step();
    check_eq("loaduse_idle_a", 32'(ctl_a), 32'(CtlRun));

    // ex_rd = 0 never stalls even when sources match
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    step();
    check_eq("loaduse_x0_a", 32'(ctl_a), 32'(CtlRun));
    clear_inputs();

    // Taken branch: 3-cycle window on dut_a, 2-cycle on dut_b
    ex_branch = 1'b1; ex_alu_zero = 1'b1; ex_branch_target = 32'h40;
    step();
    check_eq("br_ctl_a", 32'(ctl_a), 32'(CtlBrRedir));
    check_eq("br_tgt_a", tgt_a, 32'h40);
    check_eq("br_ctl_b", 32'(ctl_b), 32'(CtlBrRedir));
    clear_inputs();
    // A jump arriving inside the window is ignored
    id_jump = 1'b1; id_jump_target = 32'h80;
    step();
    check_eq("br_hold1_a", 32'(ctl_a), 32'(CtlBrHold));
    check_eq("br_hold1_tgt_a", tgt_a, 32'h40);
    check_eq("br_hold1_b", 32'(ctl_b), 32'(CtlBrHold));
    clear_inputs();
    step();
    check_eq("br_hold2_a", 32'(ctl_a), 32'(CtlBrHold));
    check_eq("br_done_b", 32'(ctl_b), 32'(CtlRun));
    step();
    check_eq("br_done_a", 32'(ctl_a), 32'(CtlRun));
    check_eq("br_tgt_kept_a", tgt_a, 32'h40);

    // Jump redirect
    id_jump = 1'b1; id_jump_target = 32'h100;
    step();
    check_eq("jmp_ctl_a", 32'(ctl_a), 32'(CtlJmpRed));
    check_eq("jmp_tgt_a", tgt_a, 32'h100);
    clear_inputs();
    step();
    check_eq("jmp_hold_a", 32'(ctl_a), 32'(CtlJmpHold));
    step();
    step();
    check_eq("jmp_done_a", 32'(ctl_a), 32'(CtlRun));

    // Branch and jump together: branch wins
    ex_branch = 1'b1; ex_alu_zero = 1'b1; ex_branch_target = 32'h40;
    id_jump = 1'b1; id_jump_target = 32'h80;
    step();
    check_eq("brjmp_ctl_a", 32'(ctl_a), 32'(CtlBrRedir));
    check_eq("brjmp_tgt_a", tgt_a, 32'h40);
    clear_inputs();
    step();
    step();
    step();
    check_eq("brjmp_done_a", 32'(ctl_a), 32'(CtlRun));

    // mem_busy for 4 cycles inside dut_b's redirect window
    ex_branch = 1'b1; ex_alu_zero = 1'b1; ex_branch_target = 32'h200;
    step();
    check_eq("busy_br_b", 32'(ctl_b), 32'(CtlBrRedir));
`ifdef HAZ_PERF_CNT_EN
    stall_base = pst_b;
`endif
    clear_inputs();
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq($sformatf("busy_frz%0d_b", i), 32'(ctl_b), 32'(CtlBrBusy));
    end
    mem_busy = 1'b0;
    step();
    check_eq("busy_resume_b", 32'(ctl_b), 32'(CtlBrHold));
    check_eq("busy_resume_tgt_b", tgt_b, 32'h200);
    step();
    check_eq("busy_done_b", 32'(ctl_b), 32'(CtlRun));
`ifdef HAZ_PERF_CNT_EN
    check_eq("perf_stall_b", 32'(pst_b - stall_base), 32'd4);
`endif
    step();
    check_eq("busy_done_a", 32'(ctl_a), 32'(CtlRun));

    // MEMWAIT from RUN; a branch present on the exit edge is not yet taken
    mem_busy = 1'b1;
    step();
    check_eq("memwait1_a", 32'(ctl_a), 32'(CtlMemWait));
    step();
    check_eq("memwait2_a", 32'(ctl_a), 32'(CtlMemWait));
    mem_busy = 1'b0;
    ex_branch = 1'b1; ex_alu_zero = 1'b1; ex_branch_target = 32'h300;
    step();
    check_eq("memwait_exit_a", 32'(ctl_a), 32'(CtlRun));
    ex_branch_target = 32'h300;
    step();
    check_eq("memwait_br_a", 32'(ctl_a), 32'(CtlBrRedir));
    check_eq("memwait_br_b", 32'(ctl_b), 32'(CtlBrRedir));
    clear_inputs();

    // Asynchronous reset in the middle of the redirect window
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_ctl_a", 32'(ctl_a), 32'(CtlRun));
    check_eq("rst_mid_tgt_a", tgt_a, 32'h0);
    check_eq("rst_mid_ctl_b", 32'(ctl_b), 32'(CtlRun));
    step();
    rst_n = 1'b1;
    step();
    check_eq("post_rst_a", 32'(ctl_a), 32'(CtlRun));

    // Taken-not-taken: branch without zero flag does not redirect
    ex_branch = 1'b1; ex_alu_zero = 1'b0; ex_branch_target = 32'h40;
    step();
    check_eq("br_not_taken_a", 32'(ctl_a), 32'(CtlRun));
    clear_inputs();

    // Single-cycle window would look like CtlBrRun; dut_b must still be in REDIRECT
    ex_branch = 1'b1; ex_alu_zero = 1'b1; ex_branch_target = 32'h44;
    step();
    check_eq("br_b_not_run", 32'(ctl_b == CtlBrRun), 32'd0);
    clear_inputs();
    step();
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central sequencer for all pipeline control hazards: load-use stalls, taken-branch and jump redirects, and data-memory busy stalls.
- Sits beside the IF/ID/EX pipeline registers. Drives PC write-enable, the PC source select and redirect target, IF/ID write-enable and the per-stage flush lines from one registered FSM.
- Arbitrates simultaneous hazards by fixed priority, so the datapath never sees conflicting stall/flush commands.

Parameters:
- ADDR_W, 32, width of PC and redirect targets
- REG_W, 5, register specifier width
- REDIRECT_CYC, 1, cycles flush lines stay asserted after a redirect (1..7)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_jump  in  1  jump decoded in ID
- id_jump_target  in  ADDR_W  jump destination
- ex_branch  in  1  branch instruction in EX
- ex_alu_zero  in  1  ALU zero flag (branch condition true)
- ex_branch_target  in  ADDR_W  branch destination
- ex_mem_read  in  1  EX instruction is a load
- ex_rd  in  REG_W  EX destination register
- id_rs1, id_rs2  in  REG_W  ID source registers
- mem_busy  in  1  data memory not ready
- pc_write  out  1  PC update enable
- pc_sel  out  2  00 PC+4, 01 jump target, 10 branch target
- pc_target  out  ADDR_W  redirect address
- if_id_write  out  1  IF/ID register enable
- if_flush, id_flush, ex_flush  out  1  stage flush/bubble insert
- ctrl_state  out  2  00 RUN, 01 STALL, 10 REDIRECT, 11 MEMWAIT

Behaviour:
- All outputs registered. Each decision is taken on a clock edge and is visible on the outputs for the following cycle.
- Async reset (rst_n=0):
  - state RUN, counter 0
  - pc_write=1, if_id_write=1
  - pc_sel=00, pc_target=0
  - all flushes 0
  - Reset mid-operation aborts any stall or redirect immediately.
- Definitions:
  - taken = ex_branch & ex_alu_zero
  - loaduse = ex_mem_read & (ex_rd!=0) & (ex_rd==id_rs1 | ex_rd==id_rs2)
- RUN, priority high to low:
  - mem_busy -> MEMWAIT: pc_write=0, if_id_write=0, flushes 0.
  - taken -> pc_sel=10, pc_target=ex_branch_target, pc_write=1, if_flush=id_flush=ex_flush=1. Next state REDIRECT if REDIRECT_CYC>1, else RUN. Counter loaded with REDIRECT_CYC-1.
  - id_jump -> pc_sel=01, pc_target=id_jump_target, pc_write=1, if_flush=id_flush=1, ex_flush=0. Next state and counter as for taken.
  - loaduse -> STALL: pc_write=0, if_id_write=0, id_flush=1 (bubble), pc_sel=00.
  - otherwise: pc_write=1, if_id_write=1, pc_sel=00, flushes 0.
- Simultaneous taken and id_jump: branch wins (older instruction). The jump is discarded by id_flush.
- STALL: lasts exactly one cycle. Inputs are ignored except mem_busy, which goes to MEMWAIT. Otherwise returns to RUN with normal outputs.
- REDIRECT:
  - pc_sel=00, pc_write=1, if_id_write=1.
  - Flush pattern of the originating event held, counter decrements.
  - taken, id_jump and loaduse are ignored (those instructions are being flushed).
  - When the counter reaches 0, go to RUN.
  - mem_busy freezes the counter and forces pc_write=0, if_id_write=0. Flushes stay asserted.
- MEMWAIT:
  - pc_write=0, if_id_write=0, flushes 0, held while mem_busy=1.
  - On mem_busy=0, go to RUN with normal outputs. Hazards are re-evaluated on the next edge.
- pc_target holds its last redirect value whenever pc_sel=00.
- Counter is 3 bits. REDIRECT_CYC values outside 1..7 are unsupported.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined: adds outputs perf_branch_cnt, perf_jump_cnt and perf_stall_cnt, each 16 bits, saturating at 16'hFFFF and cleared by rst_n.
  - perf_branch_cnt counts accepted branch redirects.
  - perf_jump_cnt counts accepted jump redirects.
  - perf_stall_cnt counts cycles with pc_write=0.
- Undefined: ports and counters absent. Core behaviour identical.

Test Plan:
- Reset: rst_n=0 mid-REDIRECT -> ctrl_state=00, pc_write=1, pc_sel=00, all flushes 0 without waiting for a clock edge.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5 -> next cycle pc_write=0, if_id_write=0, id_flush=1 for exactly 1 cycle, then RUN. Same stimulus with ex_rd=0 -> no stall.
- Taken branch: ex_branch=1, ex_alu_zero=1, target 32'h0000_0040 -> next cycle pc_sel=10, pc_target=0x40, all three flushes 1. With REDIRECT_CYC=3, flushes stay high for 3 cycles total.
- Branch+jump together: taken=1, id_jump=1, jump target 0x80, branch target 0x40 -> pc_sel=10, pc_target=0x40. Jump ignored.
- Jump: id_jump=1, target 0x100 -> pc_sel=01, if_flush=id_flush=1, ex_flush=0.
- mem_busy: held 4 cycles during REDIRECT with REDIRECT_CYC=2 -> counter frozen and pc_write=0 for 4 cycles, then flushes complete. With HAZ_PERF_CNT_EN defined, perf_stall_cnt increments by 4.
